// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the staged reset sequencer.
package rst_seq_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK,
      SEQ,
      RUN,
      HOLD
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_POR,
      CAUSE_LOCK,
      CAUSE_SW,
      CAUSE_WDT
   } cause_e;

   // Width of a down-counter that must hold values 0 .. max(a,b)-1.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rst_seq_wdt.sv
// Watchdog for the reset sequencer: fires once WDT_TIMEOUT cycles pass in RUN without a kick.
// Only built when RST_SEQ_WDT_EN is defined.
`ifdef RST_SEQ_WDT_EN
module rst_seq_wdt
   import rst_seq_pkg::*;
#(
   parameter int WDT_TIMEOUT = 1 << 20
) (
   input  logic i_aclk,
   input  logic i_rst_n,
   input  logic i_run,
   input  logic i_kick,
   output logic o_fire
);

   localparam int               WDT_W      = idx_width(WDT_TIMEOUT);
   localparam logic [WDT_W-1:0] WDT_RELOAD = WDT_W'(WDT_TIMEOUT - 1);

   logic [WDT_W-1:0] cnt_q;

   // Held at reload outside RUN so the first RUN cycle starts a full window.
   always_ff @(posedge i_aclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else if (!i_run || i_kick) begin
         cnt_q <= WDT_RELOAD;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - WDT_W'(1);
      end
   end

   assign o_fire = i_run && (cnt_q == '0);

endmodule
`endif

// File: rtl/reset_sequencer.sv
// Staged reset release after PLL lock; aborts on lock loss, soft reset or watchdog.
// Watchdog abort is present only when RST_SEQ_WDT_EN is defined.
//
// state     | meaning
// WAIT_LOCK | all stages held in reset, waiting for synchronised PLL lock
// SEQ       | releasing stages in order, STAGE_DLY cycles apart
// RUN       | all stages released; soft reset and watchdog armed
// HOLD      | all stages held for HOLD_CYCLES after a soft or watchdog reset
module reset_sequencer
   import rst_seq_pkg::*;
#(
   parameter int NUM_STAGES  = 3,
   parameter int STAGE_DLY   = 16,
   parameter int HOLD_CYCLES = 32,
   parameter int WDT_TIMEOUT = 1 << 20
) (
   input  logic                  i_aclk,
   input  logic                  i_rst_n,
   input  logic                  i_pll_locked,
   input  logic                  i_sw_rst_req,
   input  logic                  i_wdt_kick,
   output logic [NUM_STAGES-1:0] o_rst_n,
   output logic                  o_rst_done,
   output logic                  o_sw_rst_ack,
   output logic [1:0]            o_rst_cause,
   output logic                  o_wdt_fired
);

   localparam int               CNT_W        = cnt_width(STAGE_DLY, HOLD_CYCLES);
   localparam int               IDX_W        = idx_width(NUM_STAGES);
   localparam logic [CNT_W-1:0] STAGE_RELOAD = CNT_W'(STAGE_DLY - 1);
   localparam logic [CNT_W-1:0] HOLD_RELOAD  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_STAGE   = IDX_W'(NUM_STAGES - 1);

   state_e                state_q, state_d;
   cause_e                cause_q, cause_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      stage_q, stage_d;
   logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
   logic                  ack_q, ack_d;
   logic                  wdt_fired_q, wdt_fired_d;
   logic                  lock_meta, lock_sync;
   logic                  lock_lost;
   logic                  wdt_fire;

   always_ff @(posedge i_aclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lock_meta <= 1'b0;
         lock_sync <= 1'b0;
      end else begin
         lock_meta <= i_pll_locked;
         lock_sync <= lock_meta;
      end
   end

`ifdef RST_SEQ_WDT_EN
   logic in_run;
   assign in_run = (state_q == RUN);

   rst_seq_wdt #(
      .WDT_TIMEOUT (WDT_TIMEOUT)
   ) u_wdt (
      .i_aclk  (i_aclk),
      .i_rst_n (i_rst_n),
      .i_run   (in_run),
      .i_kick  (i_wdt_kick),
      .o_fire  (wdt_fire)
   );
`else
   logic unused_wdt;
   assign unused_wdt = i_wdt_kick ^ (WDT_TIMEOUT == 0);
   assign wdt_fire   = 1'b0;
`endif

   always_ff @(posedge i_aclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= WAIT_LOCK;
         cause_q     <= CAUSE_POR;
         cnt_q       <= '0;
         stage_q     <= '0;
         rst_n_q     <= '0;
         ack_q       <= 1'b0;
         wdt_fired_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cause_q     <= cause_d;
         cnt_q       <= cnt_d;
         stage_q     <= stage_d;
         rst_n_q     <= rst_n_d;
         ack_q       <= ack_d;
         wdt_fired_q <= wdt_fired_d;
      end
   end

   // Lock loss outranks every other event, so it is resolved ahead of the state case.
   assign lock_lost = !lock_sync && (state_q != WAIT_LOCK);

   always_comb begin
      state_d     = state_q;
      cause_d     = cause_q;
      cnt_d       = cnt_q;
      stage_d     = stage_q;
      rst_n_d     = rst_n_q;
      ack_d       = 1'b0;
      wdt_fired_d = wdt_fired_q;

      if (lock_lost) begin
         state_d = WAIT_LOCK;
         cause_d = CAUSE_LOCK;
         cnt_d   = '0;
         stage_d = '0;
         rst_n_d = '0;
      end else begin
         unique case (state_q)
            WAIT_LOCK: begin
               rst_n_d = '0;
               if (lock_sync) begin
                  state_d = SEQ;
                  cnt_d   = STAGE_RELOAD;
                  stage_d = '0;
               end
            end

            SEQ: begin
               if (cnt_q == '0) begin
                  for (int i = 0; i < NUM_STAGES; i++) begin
                     if (stage_q == IDX_W'(i)) rst_n_d[i] = 1'b1;
                  end
                  cnt_d = STAGE_RELOAD;
                  if (stage_q == LAST_STAGE) begin
                     state_d = RUN;
                  end else begin
                     stage_d = stage_q + IDX_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end

            RUN: begin
               if (wdt_fire || i_sw_rst_req) begin
                  state_d = HOLD;
                  cnt_d   = HOLD_RELOAD;
                  stage_d = '0;
                  rst_n_d = '0;
                  if (wdt_fire) begin
                     cause_d     = CAUSE_WDT;
                     wdt_fired_d = 1'b1;
                  end else begin
                     cause_d     = CAUSE_SW;
                     ack_d       = 1'b1;
                     wdt_fired_d = 1'b0;
                  end
               end
            end

            HOLD: begin
               rst_n_d = '0;
               if (cnt_q == '0) begin
                  state_d = WAIT_LOCK;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end

            default: begin
               state_d = WAIT_LOCK;
               rst_n_d = '0;
            end
         endcase
      end
   end

   assign o_rst_n      = rst_n_q;
   assign o_rst_done   = (state_q == RUN);
   assign o_sw_rst_ack = ack_q;
   assign o_rst_cause  = cause_q;
   assign o_wdt_fired  = wdt_fired_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expectations are queued per cycle when stimulus is
// driven and compared on the falling edge. Covers the watchdog when RST_SEQ_WDT_EN is defined.
module tb_reset_sequencer;

   localparam int NS = 3;
   localparam int SD = 4;
   localparam int HC = 8;
   localparam int WT = 64;

   logic          clk = 1'b0;
   logic          rst_n, lock, req, kick;
   logic [NS-1:0] rst_out;
   logic          done, ack, wdt;
   logic [1:0]    cause;

   int cyc    = 0;
   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      int         cyc;
      string      tag;
      logic [7:0] exp;
   } exp_t;

   exp_t       sb_q[$];
   logic [1:0] cur_cause;
   logic       cur_wdt;

   reset_sequencer #(
      .NUM_STAGES  (NS),
      .STAGE_DLY   (SD),
      .HOLD_CYCLES (HC),
      .WDT_TIMEOUT (WT)
   ) dut (
      .i_aclk       (clk),
      .i_rst_n      (rst_n),
      .i_pll_locked (lock),
      .i_sw_rst_req (req),
      .i_wdt_kick   (kick),
      .o_rst_n      (rst_out),
      .o_rst_done   (done),
      .o_sw_rst_ack (ack),
      .o_rst_cause  (cause),
      .o_wdt_fired  (wdt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Expected outputs packed as {rst_n[2:0], done, ack, cause[1:0], wdt_fired}.
   task automatic expect_at(input int c, input string tag, input logic [2:0] r,
                            input logic d, input logic a);
      exp_t e;
      e.cyc = c;
      e.tag = tag;
      e.exp = {r, d, a, cur_cause, cur_wdt};
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].cyc == cyc) begin
            check_val(sb_q[i].tag, 32'({rst_out, done, ack, cause, wdt}), 32'(sb_q[i].exp));
            sb_q.delete(i);
         end
      end
   end

   task automatic goto(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // t0 is the edge at which the FSM samples synchronised lock and enters SEQ.
   task automatic expect_seq(input int t0, input string tg);
      expect_at(t0,          {tg, "_t0"},     3'b000, 1'b0, 1'b0);
      expect_at(t0 + SD - 1, {tg, "_s0_pre"}, 3'b000, 1'b0, 1'b0);
      expect_at(t0 + SD,     {tg, "_s0"},     3'b001, 1'b0, 1'b0);
      expect_at(t0 + 2*SD-1, {tg, "_s1_pre"}, 3'b001, 1'b0, 1'b0);
      expect_at(t0 + 2*SD,   {tg, "_s1"},     3'b011, 1'b0, 1'b0);
      expect_at(t0 + 3*SD-1, {tg, "_s2_pre"}, 3'b011, 1'b0, 1'b0);
      expect_at(t0 + 3*SD,   {tg, "_s2"},     3'b111, 1'b1, 1'b0);
   endtask

   // Called from RUN at a falling edge; request is sampled on the next rising edge.
   task automatic soft_reset(input string tg, output int t0);
      int a;
      a   = cyc + 1;
      req = 1'b1;
      cur_cause = 2'd2;
      cur_wdt   = 1'b0;
      expect_at(a,      {tg, "_ack"},      3'b000, 1'b0, 1'b1);
      expect_at(a + 1,  {tg, "_ack_end"},  3'b000, 1'b0, 1'b0);
      expect_at(a + HC, {tg, "_hold_end"}, 3'b000, 1'b0, 1'b0);
      t0 = a + HC + 1;
      @(negedge clk);
      req = 1'b0;
   endtask

   initial begin
      int t0, t1, c, r, r2;
      rst_n = 1'b0;
      lock  = 1'b1;
      req   = 1'b0;
      kick  = 1'b1;
      cur_cause = 2'd0;
      cur_wdt   = 1'b0;

      // POR
      goto(5);
      check_val("por_rst_n", 32'(rst_out), 32'd0);
      check_val("por_done",  32'(done),    32'd0);
      check_val("por_ack",   32'(ack),     32'd0);
      check_val("por_cause", 32'(cause),   32'd0);
      check_val("por_wdt",   32'(wdt),     32'd0);
      rst_n = 1'b1;
      t0 = cyc + 3;
      expect_seq(t0, "por");
      goto(t0 + 3*SD + 2);

      // asynchronous assertion mid-cycle in RUN
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("arst_rst_n", 32'(rst_out), 32'd0);
      check_val("arst_done",  32'(done),    32'd0);
      @(negedge clk);
      goto(cyc + 3);
      rst_n = 1'b1;
      t0 = cyc + 3;
      expect_seq(t0, "arst");
      goto(t0 + 3*SD + 2);

      // soft reset, then a request during SEQ that must be ignored
      soft_reset("sw", t0);
      expect_seq(t0, "sw");
      goto(t0 + 5);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      goto(t0 + 3*SD + 2);

      // lock loss while stage 0 is released
      soft_reset("sw2", t0);
      expect_at(t0 + SD,     "ll_s0",    3'b001, 1'b0, 1'b0);
      expect_at(t0 + SD + 3, "ll_pre",   3'b001, 1'b0, 1'b0);
      goto(t0 + 5);
      lock = 1'b0;
      cur_cause = 2'd1;
      expect_at(t0 + 8,  "ll_abort", 3'b000, 1'b0, 1'b0);
      expect_at(t0 + 10, "ll_wait",  3'b000, 1'b0, 1'b0);
      goto(t0 + 12);
      lock = 1'b1;
      t1 = cyc + 3;
      expect_seq(t1, "relock");
      goto(t1 + 3*SD + 2);

      // same-cycle lock loss and soft request in RUN
      soft_reset("sw3", t0);
      expect_seq(t0, "sw3");
      goto(t0 + 3*SD + 2);
      c = cyc;
      lock = 1'b0;
      expect_at(c + 1, "ll5_pre1", 3'b111, 1'b1, 1'b0);
      expect_at(c + 2, "ll5_pre2", 3'b111, 1'b1, 1'b0);
      goto(c + 2);
      req = 1'b1;
      cur_cause = 2'd1;
      expect_at(c + 3, "ll5_abort", 3'b000, 1'b0, 1'b0);
      expect_at(c + 4, "ll5_noack", 3'b000, 1'b0, 1'b0);
      @(negedge clk);
      req = 1'b0;
      goto(c + 6);
      lock = 1'b1;
      t1 = cyc + 3;
      expect_seq(t1, "relock5");
      goto(t1 + 3*SD);

      // watchdog: no kicks from RUN entry
      r = cyc;
      kick = 1'b0;
      expect_at(r + WT - 1, "wdt_pre", 3'b111, 1'b1, 1'b0);
`ifdef RST_SEQ_WDT_EN
      cur_cause = 2'd3;
      cur_wdt   = 1'b1;
      expect_at(r + WT,      "wdt_fire", 3'b000, 1'b0, 1'b0);
      expect_at(r + WT + HC, "wdt_hold", 3'b000, 1'b0, 1'b0);
      t0 = r + WT + HC + 1;
      expect_seq(t0, "wdt_reseq");
      goto(t0 + 3*SD);
`else
      expect_at(r + WT,     "nowdt",      3'b111, 1'b1, 1'b0);
      expect_at(r + WT + 5, "nowdt_late", 3'b111, 1'b1, 1'b0);
      goto(r + WT + 6);
`endif
      r2 = cyc;
      for (int k = 1; k <= 6; k++) begin
         expect_at(r2 + 32*k + 1, "kick_run", 3'b111, 1'b1, 1'b0);
         goto(r2 + 32*k - 1);
         kick = 1'b1;
         @(negedge clk);
         kick = 1'b0;
      end
      expect_at(cyc + 40, "kick_tail", 3'b111, 1'b1, 1'b0);
      goto(cyc + 41);

      // accepted soft reset clears the sticky watchdog flag
      soft_reset("sw_clr", t0);
      expect_seq(t0, "sw_clr");
      goto(t0 + 3*SD + 2);

      check_val("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
